// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master.
// Contents:
//   state_e     transaction FSM states
//   Q0..Q3      quarter indices within one SCL slot
//   LAST_BIT    slot index of the final bit in an 8-bit field
//   bus_levels  maps (state, quarter, data bit) to {scl, sda, en}
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_WR,
    S_WACK,
    S_RD,
    S_RNACK,
    S_STOP
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [3:0] LAST_BIT = 4'd7;

  // Bus levels for a given state and quarter; returns {scl, sda, en}.
  // Data slots hold SCL low for q0/q1 and high for q2/q3, so SDA only
  // ever moves while SCL is low except at START and STOP.
  function automatic logic [2:0] bus_levels(state_e s, logic [1:0] q, logic b);
    logic [2:0] r;
    r = 3'b110;
    case (s)
      S_START:             r = {q != Q3, (q == Q0) || (q == Q1), 1'b1};
      S_ADDR, S_WR:        r = {q >= Q2, b, 1'b1};
      S_AACK, S_WACK, S_RD: r = {q >= Q2, 1'b1, 1'b0};
      S_RNACK:             r = {q >= Q2, 1'b1, 1'b1};
      S_STOP:              r = {q != Q0, q == Q3, 1'b1};
      default:             r = 3'b110;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period timebase for the I2C master.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   clr_i   hold divider and quarter index at zero (engine idle)
//   tick_o  one-cycle pulse on the last cycle of each quarter
//   qtr_o   current quarter index 0..3
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  output logic       tick_o,
  output logic [1:0] qtr_o
);

  localparam int Q  = CLK_DIV / 4;
  localparam int DW = (Q > 1) ? $clog2(Q) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;

  assign tick_o = (div_q == DW'(Q - 1));
  assign qtr_o  = qtr_q;

  always_comb begin
    div_d = div_q + DW'(1);
    qtr_d = qtr_q;
    if (clr_i) begin
      div_d = '0;
      qtr_d = Q0;
    end else if (tick_o) begin
      div_d = '0;
      qtr_d = qtr_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      qtr_q <= Q0;
    end else begin
      div_q <= div_d;
      qtr_q <= qtr_d;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master transaction engine:
// START, {addr,rw}, ACK, one data byte, ACK/NACK, STOP.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, rw, addr,    request and its parameters, latched when idle
//   wdata
//   busy, done          transaction in progress / one-cycle completion pulse
//   ack_err             slave NACKed address or write data (held until next start)
//   rdata               read byte, updated at done of a successful read
//   iSCL, oSDA, en      SCL level, SDA drive level, SDA drive enable to the BIU
//   iSDA                SDA as sampled by the BIU
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       iSCL,
  output logic       oSDA,
  output logic       en,
  input  logic       iSDA
);

  state_e     state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0] rdata_q, rdata_d, rx_q, rx_d;
  logic       scl_q, sda_q, en_q;
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] wdata_q;
  logic       load;

  logic       tick, slot_end;
  logic [1:0] qtr, q_nxt;
  logic [7:0] tx_byte;
  logic [2:0] bit_idx;
  logic [2:0] lvl_d;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (state_q == S_IDLE),
    .tick_o (tick),
    .qtr_o  (qtr)
  );

  assign slot_end = tick && (qtr == Q3);
  // Outputs are registered, so they are computed from the quarter and
  // state that will be current in the next cycle.
  assign q_nxt    = tick ? (qtr + 2'd1) : qtr;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    rx_d    = rx_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start in the done cycle is dropped; it must be re-presented.
        if (start && !done_q) begin
          state_d = S_START;
          slot_d  = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          load    = 1'b1;
        end
      end
      S_START: if (slot_end) state_d = S_ADDR;
      S_ADDR, S_WR, S_RD: begin
        if (slot_end) begin
          if (state_q == S_RD) rx_d = {rx_q[6:0], iSDA};
          if (slot_q == LAST_BIT) begin
            slot_d  = '0;
            state_d = (state_q == S_ADDR) ? S_AACK :
                      (state_q == S_WR)   ? S_WACK : S_RNACK;
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
      end
      S_AACK: begin
        if (slot_end) begin
          if (iSDA) begin
            err_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = rw_q ? S_RD : S_WR;
          end
        end
      end
      S_WACK: begin
        if (slot_end) begin
          if (iSDA) err_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_RNACK: if (slot_end) state_d = S_STOP;
      S_STOP: begin
        if (slot_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (rw_q && !err_q) rdata_d = rx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_byte = (state_d == S_WR) ? wdata_q : {addr_q, rw_q};
  assign bit_idx = 3'd7 - slot_d[2:0];
  assign lvl_d   = bus_levels(state_d, q_nxt, tx_byte[bit_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      {scl_q, sda_q, en_q} <= lvl_d;
    end
  end

  // Request parameters and the read shadow carry no reset.
  always_ff @(posedge clk) begin
    rx_q <= rx_d;
    if (load) begin
      rw_q    <= rw;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = err_q;
  assign rdata   = rdata_q;
  assign iSCL    = scl_q;
  assign oSDA    = sda_q;
  assign en      = en_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
module tb_i2c_master_ctrl;

  localparam int CLK_DIV = 8;

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy, done, ack_err;
  logic [7:0] rdata;
  logic       iSCL, oSDA, en, iSDA;

  int checks = 0;
  int errors = 0;
  int done_n, busy_cnt, done_cnt;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .iSCL(iSCL), .oSDA(oSDA), .en(en), .iSDA(iSDA)
  );

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       aack;      // slave ACKs address
    logic       dack;      // slave ACKs write data
    logic [7:0] sdata;     // byte the slave returns on a read
    int         exp_done;  // cycles from first busy cycle to done
    logic       exp_err;
    logic [7:0] rd_before;
    logic [7:0] exp_rdata;
    logic [7:0] exp_abyte;
    logic [7:0] exp_dbyte;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Slot numbering: 0 START, 1..8 address bits, 9 AACK, 10..17 data, 18 ACK/NACK.
  function automatic logic slave_sda(input vec_t v, input int s);
    if (s == 9) return v.aack ? 1'b0 : 1'b1;
    if (v.rw && s >= 10 && s <= 17) return v.sdata[3'(17 - s)];
    if (!v.rw && s == 18) return v.dack ? 1'b0 : 1'b1;
    return 1'b1;
  endfunction

  function automatic logic exp_en(input logic r, input int s);
    if (s <= 8) return 1'b1;
    if (s == 9) return 1'b0;
    if (s <= 17) return !r;
    return r;
  endfunction

  // Entered at a negedge with the engine idle; returns at the negedge of done.
  task automatic run_txn(input vec_t v);
    int bad_en = 0, bad_scl = 0, bad_sda = 0, bad_busy = 0;
    int last, dn;
    logic [7:0] abyte, dbyte;
    abyte = '0;
    dbyte = '0;
    dn    = -1;
    last  = v.exp_done / 8 - 1;
    rw = v.rw; addr = v.addr; wdata = v.wdata; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rw = ~v.rw; addr = ~v.addr; wdata = ~v.wdata;
    for (int n = 0; n <= 200; n++) begin
      int s, p;
      if (n > 0) @(negedge clk);
      s = n / 8;
      p = n % 8;
      if (done) begin
        dn = n;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
      if (s == 0) begin
        if (iSCL !== (p < 6)) bad_scl++;
        if (oSDA !== (p < 4)) bad_sda++;
        if (en !== 1'b1) bad_en++;
      end else if (s == last) begin
        if (iSCL !== (p >= 2)) bad_scl++;
        if (oSDA !== (p >= 6)) bad_sda++;
        if (en !== 1'b1) bad_en++;
      end else begin
        if (iSCL !== (p >= 4)) bad_scl++;
        if (en !== exp_en(v.rw, s)) bad_en++;
        if (p == 5) begin
          if (s >= 1 && s <= 8) abyte = {abyte[6:0], oSDA};
          if (s >= 10 && s <= 17) dbyte = {dbyte[6:0], oSDA};
          if (s == 18 && v.rw && oSDA !== 1'b1) bad_sda++;
        end
      end
      if (n == v.exp_done - 1) chk("rdata_before_done", 32'(rdata), 32'(v.rd_before));
      iSDA = slave_sda(v, s);
    end
    iSDA = 1'b1;
    chk("done_latency", dn, v.exp_done);
    chk("busy_during_txn", bad_busy, 0);
    chk("scl_pattern", bad_scl, 0);
    chk("sda_pattern", bad_sda, 0);
    chk("en_pattern", bad_en, 0);
    chk("addr_byte", 32'(abyte), 32'(v.exp_abyte));
    if (!v.rw && v.aack) chk("data_byte", 32'(dbyte), 32'(v.exp_dbyte));
    chk("done_busy", 32'(busy), 0);
    chk("done_ack_err", 32'(ack_err), 32'(v.exp_err));
    chk("done_rdata", 32'(rdata), 32'(v.exp_rdata));
    chk("done_scl_idle", 32'(iSCL), 1);
    chk("done_en_idle", 32'(en), 0);
  endtask

  initial begin
    //          rw    addr   wdata  aack  dack  sdata  done err   rd_bef rdata  abyte  dbyte
    vecs[0] = '{1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 160, 1'b0, 8'h00, 8'h00, 8'hA0, 8'hA5};
    vecs[1] = '{1'b1, 7'h21, 8'h00, 1'b1, 1'b1, 8'h3C, 160, 1'b0, 8'h00, 8'h3C, 8'h43, 8'h00};
    vecs[2] = '{1'b1, 7'h12, 8'h00, 1'b0, 1'b1, 8'h99,  88, 1'b1, 8'h3C, 8'h3C, 8'h25, 8'h00};
    vecs[3] = '{1'b0, 7'h0F, 8'h3C, 1'b1, 1'b0, 8'h00, 160, 1'b1, 8'h3C, 8'h3C, 8'h1E, 8'h3C};

    // Reset with start held high
    rst = 1'b1; start = 1'b1; rw = 1'b0; addr = 7'h50; wdata = 8'hA5; iSDA = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_iSCL", 32'(iSCL), 1);
      chk("rst_oSDA", 32'(oSDA), 1);
      chk("rst_en", 32'(en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ack_err", 32'(ack_err), 0);
      chk("rst_rdata", 32'(rdata), 0);
    end
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run_txn(vecs[i]);
    end

    // Start coincident with done is dropped, next cycle it is taken
    rw = 1'b0; addr = 7'h50; wdata = 8'hA5; start = 1'b1;
    @(negedge clk);
    chk("start_at_done_ignored", 32'(busy), 0);
    chk("ack_err_held", 32'(ack_err), 1);
    @(negedge clk);
    chk("start_after_done_accepted", 32'(busy), 1);
    chk("ack_err_cleared", 32'(ack_err), 0);
    start = 1'b0;
    done_n = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 20) begin start = 1'b1; rw = 1'b1; addr = 7'h11; end
      if (n == 22) start = 1'b0;
      if (done) begin
        done_n = n;
        break;
      end
    end
    chk("addr_nack_latency", done_n, 88);
    chk("addr_nack_ack_err", 32'(ack_err), 1);
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("start_while_busy_not_queued", busy_cnt, 0);

    // Reset pulse during the fifth address bit
    rw = 1'b0; addr = 7'h50; wdata = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (43) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_iSCL", 32'(iSCL), 1);
    chk("midrst_en", 32'(en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rdata", 32'(rdata), 0);
    done_cnt = 0;
    busy_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_stays_idle", busy_cnt, 0);

    // Engine is usable again after the reset
    run_txn(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
